apb_bus_bridge: RTL and testbench

- Parametrised successor to the single-RAM MCU data bus.
- Sits between the CPU_RV32I data-bus port (busWe/busAddr/busWData/busFunc3/busRData) and NUM_SLAVES memory-mapped peripherals.
- Converts each CPU request into an APB-style SETUP/ACCESS transfer with a ready/wait handshake, address decode and a timeout error.
- Adds multi-slave decode, slave wait states and error signalling, none of which the direct CPU–RAM connection has.

---
 rtl/apb_bus_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_bus_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_bus_bridge
// Purpose  : CPU data-bus to multi-slave APB-style bridge with slot address
//            decode, slave wait states and a bounded-ACCESS error response.
// Revision : 1.0 - initial release
// ============================================================================
module apb_bus_bridge #(
  parameter int                NUM_SLAVES = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                SLOT_SHIFT = 12,
  parameter int                TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         transfer,
  input  logic                         busWe,
  input  logic [ADDR_W-1:0]            busAddr,
  input  logic [DATA_W-1:0]            busWData,
  input  logic [2:0]                   busFunc3,
  output logic [DATA_W-1:0]            busRData,
  output logic                         ready,
  output logic                         err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [2:0]                   PFUNC3,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ADDR_W-1:0]       paddr_q;
  logic                    pwrite_q;
  logic [DATA_W-1:0]       pwdata_q;
  logic [2:0]              pfunc3_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    ready_q;
  logic                    err_q;

  logic [ADDR_W-1:0]       w_off;
  logic [ADDR_W-1:0]       w_slot;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_idx;
  logic [NUM_SLAVES-1:0]   w_psel_dec;
  logic                    w_sel_ready;
  logic [DATA_W-1:0]       w_sel_rdata;
  logic                    w_timeout;

  // Slot decode: the subtraction wraps for addresses below BASE_ADDR, so the
  // explicit lower-bound compare is what rejects them.
  assign w_off      = busAddr - BASE_ADDR;
  assign w_slot     = w_off >> SLOT_SHIFT;
  assign w_hit      = (busAddr >= BASE_ADDR) && (w_slot < ADDR_W'(NUM_SLAVES));
  assign w_idx      = w_slot[IDX_W-1:0];
  assign w_psel_dec = NUM_SLAVES'(1) << w_idx;

  assign w_sel_ready = PREADY[idx_q];
  assign w_sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];
  assign w_timeout   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pfunc3_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (transfer) begin
            paddr_q  <= busAddr;
            pwrite_q <= busWe;
            pwdata_q <= busWData;
            pfunc3_q <= busFunc3;
            idx_q    <= w_idx;
            if (w_hit) begin
              psel_q  <= w_psel_dec;
              state_q <= S_SETUP;
            end else begin
              state_q <= S_ERROR;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            rdata_q   <= pwrite_q ? '0 : w_sel_rdata;
            ready_q   <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (w_timeout) begin
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ERROR: begin
          ready_q <= 1'b1;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busRData = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PWDATA   = pwdata_q;
  assign PFUNC3   = pfunc3_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_bus_bridge
// Purpose  : Self-checking bench for apb_bus_bridge (4 slots, TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_bus_bridge;

  logic         clk;
  logic         rst;
  logic         transfer;
  logic         busWe;
  logic [31:0]  busAddr;
  logic [31:0]  busWData;
  logic [2:0]   busFunc3;
  logic [31:0]  busRData;
  logic         ready;
  logic         err;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [2:0]   PFUNC3;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;

  apb_bus_bridge #(
    .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32),
    .BASE_ADDR(32'h1000_0000), .SLOT_SHIFT(12), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .transfer(transfer), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .busFunc3(busFunc3),
    .busRData(busRData), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PFUNC3(PFUNC3),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  bit          noise_en = 1'b0;

  bit          obs_done;
  int          obs_cycles, obs_acc, obs_first_cyc;
  logic [31:0] obs_rdata;
  logic        obs_err, obs_first_pen, obs_end_pen;
  logic [3:0]  obs_psel_or, obs_psel_first, obs_end_psel;
  bit          obs_psel_chg, obs_unstable;

  // Reference model: outcome of one transfer from the address map and the
  // number of ACCESS cycles the slave holds PREADY low.
  int          m_slot, m_cycles, m_acc;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [3:0]  m_psel;

  task automatic model(input logic we, input logic [31:0] a, input int waits);
    longint off;
    logic [127:0] sh;
    off = longint'(a) - longint'(32'h1000_0000);
    if (off < 0 || (off / 4096) >= 4) begin
      m_slot = -1; m_cycles = 2; m_acc = 0; m_err = 1'b1;
    end else begin
      m_slot = int'(off / 4096);
      if (waits >= 8) begin
        m_acc = 8; m_cycles = 10; m_err = 1'b1;
      end else begin
        m_acc = waits + 1; m_cycles = 3 + waits; m_err = 1'b0;
      end
    end
    m_psel = (m_slot < 0) ? 4'b0 : 4'(1 << m_slot);
    sh = (m_slot < 0) ? 128'b0 : (PRDATA >> (32 * m_slot));
    m_rdata = (m_err || we) ? 32'h0 : sh[31:0];
  endtask

  task automatic start_xfer(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f);
    transfer = 1'b1; busWe = we; busAddr = a; busWData = d; busFunc3 = f;
    cur_we = we; cur_addr = a; cur_wdata = d; cur_f3 = f;
    PRDATA = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Acts as the selected slave and records what the bridge did, cycle by
  // cycle, until the ready pulse (or a 40-cycle bound).
  task automatic run_xfer(input int waits);
    obs_done = 0; obs_cycles = 0; obs_acc = 0; obs_first_cyc = -1;
    obs_psel_or = 0; obs_psel_first = 0; obs_psel_chg = 0; obs_unstable = 0;
    obs_first_pen = 1'b0; obs_rdata = 'x; obs_err = 'x;
    obs_end_psel = 'x; obs_end_pen = 'x;
    PREADY = 4'b0;
    while (!obs_done && obs_cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      obs_cycles++;
      if (ready) begin
        obs_done = 1; obs_rdata = busRData; obs_err = err;
        obs_end_psel = PSEL; obs_end_pen = PENABLE;
        transfer = 1'b0; PREADY = 4'b0;
      end else begin
        if (PSEL != 4'b0) begin
          if (obs_first_cyc < 0) begin
            obs_first_cyc = obs_cycles; obs_psel_first = PSEL; obs_first_pen = PENABLE;
          end else if (PSEL != obs_psel_first) begin
            obs_psel_chg = 1;
          end
          if (PADDR !== cur_addr || PWRITE !== cur_we || PWDATA !== cur_wdata ||
              PFUNC3 !== cur_f3)
            obs_unstable = 1;
        end
        obs_psel_or |= PSEL;
        if (PENABLE) obs_acc++;
        PREADY = ((obs_acc > waits) ? PSEL : 4'b0) |
                 (noise_en ? (4'($urandom) & ~PSEL) : 4'b0);
      end
    end
    if (!obs_done) transfer = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; transfer = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
    busFunc3 = '0; PRDATA = '0; PREADY = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({PSEL, PENABLE, ready, err, PWRITE, PFUNC3, PADDR, PWDATA, busRData} !== '0)
      $display("FAIL reset_outputs: PSEL=%b PENABLE=%b ready=%b err=%b PADDR=%h busRData=%h expected all zero",
               PSEL, PENABLE, ready, err, PADDR, busRData);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({PSEL, PENABLE, ready, err} !== 4'b0)
      $display("FAIL reset_idle: PSEL=%b PENABLE=%b ready=%b err=%b expected 0", PSEL, PENABLE, ready, err);
    else passed++;
  endtask

  task automatic test_write;
    start_xfer(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010);
    run_xfer(0);
    total++; if (!obs_done) $display("FAIL write_done: no ready within bound"); else passed++;
    total++; if (obs_cycles !== 3) $display("FAIL write_latency: got %0d expected 3", obs_cycles); else passed++;
    total++; if (obs_err !== 1'b0) $display("FAIL write_err: got %b expected 0", obs_err); else passed++;
    total++; if (obs_psel_or !== 4'b0010 || obs_psel_chg) $display("FAIL write_psel: got %b changed=%0d expected 0010 stable", obs_psel_or, obs_psel_chg); else passed++;
    total++; if (obs_first_pen !== 1'b0 || obs_acc !== 1) $display("FAIL write_phases: setup PENABLE=%b access=%0d expected 0 and 1", obs_first_pen, obs_acc); else passed++;
    total++; if (obs_unstable) $display("FAIL write_stable: PADDR/PWDATA/PWRITE/PFUNC3 changed, got 1 expected 0"); else passed++;
    total++; if (obs_rdata !== 32'h0) $display("FAIL write_rdata: got %h expected 0", obs_rdata); else passed++;
  endtask

  task automatic test_read_wait;
    start_xfer(1'b0, 32'h1000_3010, 32'h0, 3'b010);
    PRDATA[96 +: 32] = 32'h1234_5678;
    run_xfer(4);
    total++; if (obs_cycles !== 7) $display("FAIL read_latency: got %0d expected 7", obs_cycles); else passed++;
    total++; if (obs_rdata !== 32'h1234_5678) $display("FAIL read_data: got %h expected 12345678", obs_rdata); else passed++;
    total++; if (obs_err !== 1'b0) $display("FAIL read_err: got %b expected 0", obs_err); else passed++;
    total++; if (obs_psel_or !== 4'b1000 || obs_psel_chg || obs_acc !== 5) $display("FAIL read_psel: got %b changed=%0d access=%0d expected 1000 stable 5", obs_psel_or, obs_psel_chg, obs_acc); else passed++;
    total++; if (obs_unstable) $display("FAIL read_stable: address phase changed, got 1 expected 0"); else passed++;
  endtask

  task automatic test_miss;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0FFF_FFFC; addrs[1] = 32'h1000_4000;
    for (int i = 0; i < 2; i++) begin
      start_xfer(1'b0, addrs[i], 32'h0, 3'b010);
      run_xfer(0);
      total++; if (obs_cycles !== 2) $display("FAIL miss_latency[%0d]: got %0d expected 2", i, obs_cycles); else passed++;
      total++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL miss_resp[%0d]: err=%b rdata=%h expected err=1 rdata=0", i, obs_err, obs_rdata); else passed++;
      total++; if (obs_psel_or !== 4'b0) $display("FAIL miss_psel[%0d]: got %b expected 0000", i, obs_psel_or); else passed++;
    end
  endtask

  task automatic test_timeout;
    start_xfer(1'b0, 32'h1000_0000, 32'h0, 3'b000);
    run_xfer(1000);
    total++; if (obs_acc !== 8 || obs_cycles !== 10) $display("FAIL timeout_len: access=%0d cycles=%0d expected 8 and 10", obs_acc, obs_cycles); else passed++;
    total++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL timeout_resp: err=%b rdata=%h expected err=1 rdata=0", obs_err, obs_rdata); else passed++;
    total++; if (obs_end_psel !== 4'b0 || obs_end_pen !== 1'b0) $display("FAIL timeout_drop: PSEL=%b PENABLE=%b expected 0", obs_end_psel, obs_end_pen); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    start_xfer(1'b0, 32'h1000_2008, 32'h0, 3'b010);
    exp_rd = PRDATA[64 +: 32];
    run_xfer(0);
    total++; if (obs_rdata !== exp_rd || obs_err !== 1'b0) $display("FAIL b2b_first: rdata=%h err=%b expected %h 0", obs_rdata, obs_err, exp_rd); else passed++;
    total++; if (obs_end_psel !== 4'b0) $display("FAIL b2b_overlap: PSEL at ready=%b expected 0000", obs_end_psel); else passed++;
    start_xfer(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 3'b001);
    run_xfer(0);
    total++; if (obs_first_cyc !== 1 || obs_psel_first !== 4'b0001) $display("FAIL b2b_second: PSEL %b at cycle %0d after ready expected 0001 at 1", obs_psel_first, obs_first_cyc); else passed++;
    total++; if (obs_cycles !== 3 || obs_err !== 1'b0) $display("FAIL b2b_second_done: cycles=%0d err=%b expected 3 0", obs_cycles, obs_err); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    start_xfer(1'b0, 32'h1000_1000, 32'h0, 3'b010);
    PREADY = 4'b0;
    n = 0;
    while (!PENABLE && n < 10) begin
      @(posedge clk); @(negedge clk); n++;
    end
    total++; if (PENABLE !== 1'b1) $display("FAIL rstmid_reach: PENABLE=%b expected 1", PENABLE); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if ({PSEL, PENABLE, ready} !== 6'b0) $display("FAIL rstmid_async: PSEL=%b PENABLE=%b ready=%b expected 0", PSEL, PENABLE, ready); else passed++;
    transfer = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({PSEL, PENABLE, ready} !== 6'b0) $display("FAIL rstmid_idle: PSEL=%b PENABLE=%b ready=%b expected 0", PSEL, PENABLE, ready); else passed++;
    start_xfer(1'b1, 32'h1000_1ffc, 32'h0BAD_CAFE, 3'b000);
    run_xfer(2);
    total++; if (obs_cycles !== 5 || obs_err !== 1'b0 || obs_psel_or !== 4'b0010) $display("FAIL rstmid_next: cycles=%0d err=%b PSEL=%b expected 5 0 0010", obs_cycles, obs_err, obs_psel_or); else passed++;
  endtask

  task automatic test_random;
    logic        we;
    logic [31:0] a;
    int          waits, kind;
    noise_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      kind  = $urandom_range(0, 5);
      waits = $urandom_range(0, 9);
      we    = 1'($urandom);
      if (kind == 0)      a = $urandom & 32'h0FFF_FFFC;
      else if (kind == 1) a = 32'h1000_4000 + ($urandom & 32'h00FF_FFFC);
      else                a = 32'h1000_0000 + ($urandom_range(0, 3) << 12) + ($urandom & 32'h0000_0FFC);
      start_xfer(we, a, $urandom, 3'($urandom));
      model(we, a, waits);
      run_xfer(waits);
      total++; if (obs_cycles !== m_cycles) $display("FAIL rnd_latency[%0d] addr=%h: got %0d expected %0d", i, a, obs_cycles, m_cycles); else passed++;
      total++; if (obs_err !== m_err) $display("FAIL rnd_err[%0d] addr=%h: got %b expected %b", i, a, obs_err, m_err); else passed++;
      total++; if (obs_rdata !== m_rdata) $display("FAIL rnd_rdata[%0d] addr=%h: got %h expected %h", i, a, obs_rdata, m_rdata); else passed++;
      total++; if (obs_psel_or !== m_psel || obs_psel_chg) $display("FAIL rnd_psel[%0d] addr=%h: got %b expected %b", i, a, obs_psel_or, m_psel); else passed++;
      total++; if (obs_acc !== m_acc || obs_unstable) $display("FAIL rnd_access[%0d] addr=%h: access=%0d unstable=%0d expected %0d 0", i, a, obs_acc, obs_unstable, m_acc); else passed++;
    end
    noise_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
